// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: sequences CALL/RET/RETI/IRQ into return-stack push/pop and PC/flags reload strobes.
// Ports: clk/rst (async, active-high); decoder commands call_i/ret_i/reti_i, level irq_i;
// pc_i/flags_i/target_i current state; stk_top_* from the stack; stk_* push/pop strobes and data;
// pc_load_o/pc_next_o and flags_load_o/flags_next_o reload strobes; busy_o stall, irq_ack_o,
// in_isr_o, depth_o and sticky overflow_o/underflow_o.
module call_stack_ctrl #(
  parameter int PC_W = 9,
  parameter int FLAG_W = 4,
  parameter int DEPTH = 5,
  parameter logic [PC_W-1:0] IRQ_VECTOR = 'h100,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [PC_W-1:0]   target_i,
  input  logic              call_i,
  input  logic              ret_i,
  input  logic              reti_i,
  input  logic              irq_i,
  input  logic [PC_W-1:0]   stk_top_pc_i,
  input  logic [FLAG_W-1:0] stk_top_flags_i,
  output logic              stk_push_o,
  output logic              stk_pop_o,
  output logic [PC_W-1:0]   stk_pc_o,
  output logic [FLAG_W-1:0] stk_flags_o,
  output logic              pc_load_o,
  output logic [PC_W-1:0]   pc_next_o,
  output logic              flags_load_o,
  output logic [FLAG_W-1:0] flags_next_o,
  output logic              busy_o,
  output logic              irq_ack_o,
  output logic              in_isr_o,
  output logic [DW-1:0]     depth_o,
  output logic              overflow_o,
  output logic              underflow_o
);
  typedef enum logic [2:0] {S_IDLE, S_CPUSH, S_CJUMP, S_POP, S_IPUSH, S_IJUMP} state_t;
  state_t r_state, w_next;
  logic [PC_W-1:0] r_pc, r_tgt;
  logic [FLAG_W-1:0] r_flags;
  logic r_reti, r_in_isr, r_ovf, r_unf;
  logic [DW-1:0] r_depth;
  logic w_push, w_pop_ok;
  assign w_push = (r_state == S_CPUSH) || (r_state == S_IPUSH);
  // A pop at depth 0 is an underflow: the cycle is spent but nothing is strobed.
  assign w_pop_ok = (r_state == S_POP) && (r_depth != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = S_IDLE;
    stk_push_o = 1'b0;
    stk_pop_o = 1'b0;
    stk_pc_o = '0;
    stk_flags_o = '0;
    pc_load_o = 1'b0;
    pc_next_o = '0;
    flags_load_o = 1'b0;
    flags_next_o = '0;
    irq_ack_o = 1'b0;
    case (r_state)
      S_IDLE: w_next = (reti_i || ret_i) ? S_POP : call_i ? S_CPUSH :
                       (irq_i && !r_in_isr) ? S_IPUSH : S_IDLE;
      S_CPUSH, S_IPUSH: begin
        w_next = (r_state == S_CPUSH) ? S_CJUMP : S_IJUMP;
        stk_push_o = 1'b1;
        stk_pc_o = r_pc;
        stk_flags_o = r_flags;
      end
      S_CJUMP: begin
        pc_load_o = 1'b1;
        pc_next_o = r_tgt;
      end
      S_IJUMP: begin
        pc_load_o = 1'b1;
        pc_next_o = IRQ_VECTOR;
        irq_ack_o = 1'b1;
      end
      S_POP: begin
        stk_pop_o = w_pop_ok;
        pc_load_o = w_pop_ok;
        pc_next_o = w_pop_ok ? stk_top_pc_i : '0;
        flags_load_o = w_pop_ok && r_reti;
        flags_next_o = (w_pop_ok && r_reti) ? stk_top_flags_i : '0;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc <= '0;
      r_tgt <= '0;
      r_flags <= '0;
      r_reti <= 1'b0;
      r_in_isr <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_depth <= '0;
    end else begin
      // Capture every idle cycle; only the accepted command's values are ever used.
      if (r_state == S_IDLE) begin
        r_reti <= reti_i;
        r_pc <= call_i ? pc_i + 1'b1 : pc_i;
        r_tgt <= target_i;
        r_flags <= flags_i;
      end
      if (w_push) begin
        if (r_depth == DW'(DEPTH)) r_ovf <= 1'b1;
        else r_depth <= r_depth + 1'b1;
      end
      if (r_state == S_POP) begin
        if (r_depth == '0) r_unf <= 1'b1;
        else begin
          r_depth <= r_depth - 1'b1;
          if (r_reti) r_in_isr <= 1'b0;
        end
      end
      if (r_state == S_IJUMP) r_in_isr <= 1'b1;
    end
  assign busy_o = (r_state != S_IDLE);
  assign in_isr_o = r_in_isr;
  assign depth_o = r_depth;
  assign overflow_o = r_ovf;
  assign underflow_o = r_unf;
endmodule

// File: doc/call_stack_ctrl.md
# call_stack_ctrl

Sequencer for the 5-entry return stack (9-bit PC, 4-bit flags). Turns decoder CALL/RET/RETI commands and an external interrupt request into the stack's push/pop strobes and the PC/flags reload strobes. Tracks stack depth, flags overflow and underflow, and stalls the core while a sequence is in flight. Sits between the instruction decoder, the PC register, the flags register and the `stack` block.

## Interface
- `PC_W`, 9, PC / return-address width
- `FLAG_W`, 4, flags width
- `DEPTH`, 5, stack entries; must match the `stack` instance
- `IRQ_VECTOR`, 9'h100, interrupt entry address
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `pc_i` in PC_W — address of the current instruction
- `flags_i` in FLAG_W — current flags
- `target_i` in PC_W — CALL destination
- `call_i` / `ret_i` / `reti_i` in 1 each — single-cycle decoder command pulses
- `irq_i` in 1 — level interrupt request, held until `irq_ack_o`
- `stk_top_pc_i` in PC_W — stack `out_pc`
- `stk_top_flags_i` in FLAG_W — stack `out_flags`
- `stk_push_o` / `stk_pop_o` out 1 — stack `push_en` / `pop_en`
- `stk_pc_o` out PC_W, `stk_flags_o` out FLAG_W — stack `in_pc` / `in_flags`
- `pc_load_o` out 1, `pc_next_o` out PC_W — PC reload strobe and value
- `flags_load_o` out 1, `flags_next_o` out FLAG_W — flags restore strobe and value
- `busy_o` out 1 — sequence in progress; decoder stalls
- `irq_ack_o` out 1 — one-cycle interrupt acknowledge
- `in_isr_o` out 1 — servicing an interrupt; further irq masked
- `depth_o` out clog2(DEPTH+1) — valid entries, 0..DEPTH
- `overflow_o` / `underflow_o` out 1 — sticky error flags

## Operation
- States: IDLE, CPUSH, CJUMP, POP, IPUSH, IJUMP. `busy_o` = (state != IDLE).
- Commands are sampled only in IDLE. They are ignored while busy.
- Priority in IDLE: reti > ret > call > irq. irq is taken only when `in_isr_o`=0.
- **CALL:** capture ret = pc_i+1 (mod 2^PC_W) and target_i.
  - CPUSH: `stk_push_o`=1, `stk_pc_o`=ret, `stk_flags_o`=flags_i (captured).
  - CJUMP: `pc_load_o`=1, `pc_next_o`=target. Then IDLE.
- **RET/RETI** (state POP, one cycle):
  - `stk_pop_o`=1, `pc_load_o`=1, `pc_next_o`=stk_top_pc_i. The top is still valid in this cycle; the pop takes effect at the closing edge.
  - RETI additionally: `flags_load_o`=1, `flags_next_o`=stk_top_flags_i, and clears in_isr.
- **IRQ:** capture pc_i (resume address, not +1) and flags_i.
  - IPUSH: push them.
  - IJUMP: `pc_load_o`=1, `pc_next_o`=IRQ_VECTOR, `irq_ack_o`=1, in_isr set at the closing edge.
- **Depth:** push increments and saturates at DEPTH. Push at DEPTH still strobes `stk_push_o` (the stack drops its oldest entry), depth stays DEPTH and `overflow_o` is set. Pop decrements.
- **Underflow:** RET/RETI with depth=0 still spends one cycle in POP, but all strobes stay 0, `underflow_o` is set and in_isr is unchanged.
- Sticky flags clear only on reset.
- Strobe outputs are decoded from state and captured registers. Exactly one strobe group is active per cycle.

## Timing
- Reset (asynchronous, any state): state=IDLE; all strobes, `busy_o`, `irq_ack_o`, `in_isr_o`, `depth_o`, `overflow_o`, `underflow_o` = 0; data outputs = 0.
- Stack contents are not reset; depth=0 makes them unreachable.
- Command accepted in cycle T:
  - CALL/IRQ: push in T+1, PC load in T+2, IDLE in T+3.
  - RET/RETI: pop + load in T+1, IDLE in T+2.
- A request arriving in the cycle busy falls back to 0 (i.e. while in IDLE) is accepted: back-to-back issue.
- `depth_o` updates at the edge that ends the push/pop cycle.
- The stack and the controller share `clk`. The stack's `out_pc` after a push equals the pushed value, so no extra read cycle is needed.

## Test plan
- **CALL then RET:** reset, pc_i=9'h010, flags_i=4'hC, call_i pulse with target_i=9'h080.
  - Required: push of 9'h011/4'hC in T+1; pc_load 9'h080 in T+2; depth 1.
  - Then ret_i: pc_load 9'h011, `flags_load_o`=0, depth 0.
- **Overflow:** 6 CALLs with distinct pc_i.
  - Required: depth saturates at 5, `overflow_o`=1 after the 6th.
  - Then 5 RETs return the last five return addresses in reverse order.
- **Underflow:** ret_i at depth 0 → `underflow_o`=1, no pop or pc_load, `busy_o` high for exactly 1 cycle.
- **Interrupt:** irq_i held with pc_i=9'h1FF, flags 4'h3.
  - Required: push 9'h1FF/4'h3; then pc_load 9'h100 with `irq_ack_o`; `in_isr_o`=1.
  - A second irq is masked until reti_i, which restores flags 4'h3 and PC 9'h1FF.
- **Arbitration:** call_i and irq_i in the same IDLE cycle → CALL sequence first, IRQ sequence starts the cycle after it returns to IDLE. Return address wrap: pc_i=9'h1FF with call_i pushes 9'h000.
- **Reset mid-sequence:** assert rst during CJUMP → outputs 0 immediately, `depth_o`=0, no pc_load after release.
